// File: rtl/multdiv_if.sv
// multdiv_if: operand/control/result bundle between the execute stage and
// the multi-cycle multiply/divide unit.
//   data_operandA/B  operands, sampled only on the start cycle
//   ctrl_MULT/DIV    1-cycle start pulses (MULT has priority)
//   data_result      low WIDTH bits of product, or quotient
//   data_exception   overflow / divide-by-zero, valid with data_resultRDY
//   data_resultRDY   1-cycle pulse marking result/exception valid
// Modports: master = requester (execute stage / bench), slave = multdiv.
interface multdiv_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv.sv
// multdiv: multi-cycle signed WIDTH-bit multiply/divide unit.
//   Multiply: radix-2 shift-add, WIDTH iterations; with MULTDIV_BOOTH4_EN
//             defined, radix-4 Booth recoding, WIDTH/2 iterations.
//   Divide:   restoring (non-performing) on magnitudes, DIV_ITERS iterations,
//             quotient negated when operand signs differ (truncates to zero).
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     multdiv_if.slave (operands, start pulses, result/exception/RDY)
// A start pulse in any state aborts the running op and restarts with the
// new operands; the aborted op never pulses data_resultRDY. Results and
// exception hold until the next completion; data_resultRDY marks validity.
module multdiv #(
  parameter int WIDTH     = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic      clock,
  input  logic      resetn,
  multdiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_ITERS = WIDTH / 2;
  localparam int MUL_SHIFT = 2;
`else
  localparam int MUL_ITERS = WIDTH;
  localparam int MUL_SHIFT = 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DIV,
    DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;

  // multiply datapath
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
`ifdef MULTDIV_BOOTH4_EN
  logic               booth_prev;
`endif
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     mul_hi;
  logic               mul_exc;
  logic               mul_last;

  // divide datapath
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;
  logic               neg_q;
  logic               div_ovf;
  logic               div_zero;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               div_last;
  logic               unused_div_bits;

  // operand conditioning
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  // registered outputs
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;

  assign op_a  = bus.data_operandA;
  assign op_b  = bus.data_operandB;
  // -0x8000... stays 0x8000..., which read unsigned is the correct magnitude
  assign abs_a = op_a[WIDTH-1] ? -op_a : op_a;
  assign abs_b = op_b[WIDTH-1] ? -op_b : op_b;

  assign mul_last = (cnt == CW'(MUL_ITERS - 1));
  assign div_last = (cnt == CW'(DIV_ITERS - 1));

  // One multiply step. The 2W-bit accumulator holds the exact signed
  // product; the multiplicand is kept sign-extended and shifted left.
  always_comb begin
    acc_next = acc;
`ifdef MULTDIV_BOOTH4_EN
    case ({mplier[1:0], booth_prev})
      3'b001, 3'b010: acc_next = acc + mcand;
      3'b011:         acc_next = acc + (mcand << 1);
      3'b100:         acc_next = acc - (mcand << 1);
      3'b101, 3'b110: acc_next = acc - mcand;
      default:        acc_next = acc;
    endcase
`else
    // the multiplier MSB carries weight -2^(W-1), so its partial product
    // is subtracted rather than added
    if (mplier[0]) begin
      acc_next = mul_last ? (acc - mcand) : (acc + mcand);
    end
`endif
  end

  // product fits signed WIDTH iff bits [2W-1:W-1] are a pure sign extension
  assign mul_hi  = acc_next[2*WIDTH-1:WIDTH-1];
  assign mul_exc = ~((&mul_hi) | ~(|mul_hi));

  // One restoring-divide step: shift in the next dividend bit and keep the
  // difference only when it does not go negative.
  assign div_trial = {rem, quo[WIDTH-1]};
  assign div_diff  = div_trial - {1'b0, dvsr};
  assign div_ge    = (div_trial >= {1'b0, dvsr});
  assign rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], div_ge};
  // remainder stays below the divisor (<= 2^(W-1)), so the top bit is never needed
  assign unused_div_bits = div_diff[WIDTH];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
`ifdef MULTDIV_BOOTH4_EN
      booth_prev <= 1'b0;
`endif
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      neg_q      <= 1'b0;
      div_ovf    <= 1'b0;
      div_zero   <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.ctrl_MULT) begin
        state      <= MULT;
        cnt        <= '0;
        acc        <= '0;
        mcand      <= {{WIDTH{op_a[WIDTH-1]}}, op_a};
        mplier     <= op_b;
`ifdef MULTDIV_BOOTH4_EN
        booth_prev <= 1'b0;
`endif
      end else if (bus.ctrl_DIV) begin
        // divide-by-zero still passes through DIV for one cycle so that
        // RDY lands in the cycle after E1
        state    <= DIV;
        cnt      <= '0;
        rem      <= '0;
        quo      <= abs_a;
        dvsr     <= abs_b;
        neg_q    <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        div_zero <= (op_b == '0);
        div_ovf  <= (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
      end else begin
        case (state)
          MULT: begin
            acc    <= acc_next;
            mcand  <= mcand << MUL_SHIFT;
            mplier <= mplier >> MUL_SHIFT;
`ifdef MULTDIV_BOOTH4_EN
            booth_prev <= mplier[1];
`endif
            cnt    <= cnt + CW'(1);
            if (mul_last) begin
              state    <= DONE;
              result_q <= acc_next[WIDTH-1:0];
              exc_q    <= mul_exc;
              rdy_q    <= 1'b1;
            end
          end
          DIV: begin
            if (div_zero) begin
              state    <= DONE;
              result_q <= '0;
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
            end else begin
              rem <= rem_next;
              quo <= quo_next;
              cnt <= cnt + CW'(1);
              if (div_last) begin
                state    <= DONE;
                result_q <= neg_q ? -quo_next : quo_next;
                exc_q    <= div_ovf;
                rdy_q    <= 1'b1;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: randomized self-checking bench for multdiv. A behavioural model
// (plain integer multiply/divide plus a latency deadline) predicts RDY,
// result and exception every cycle; directed spec cases also pin the model
// with literal expected values and exact RDY cycles.
module tb_multdiv;

`ifdef MULTDIV_BOOTH4_EN
  localparam int MUL_LAT = 16;
`else
  localparam int MUL_LAT = 32;
`endif
  localparam int DIV_LAT = 32;

  logic clock;
  logic resetn;

  multdiv_if #(.WIDTH(32)) bus ();

  multdiv #(.WIDTH(32), .DIV_ITERS(32)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // model state
  int          cyc = 0;
  bit          pending = 0;
  int          due = 0;
  logic [31:0] exp_res = '0;
  bit          exp_exc = 0;
  bit          rdy_exp = 0;
  logic [31:0] held_res = '0;
  bit          held_exc = 0;

  // literal expectation handshake (armed by driver, resolved by checker)
  int          lit_id = 0;
  int          lit_done_id = 0;
  int          lit_due = 0;
  logic [31:0] lit_res = '0;
  bit          lit_exc = 0;

  int checks = 0;
  int errors = 0;

  function automatic void model_op(input bit is_mul, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] r,
                                   output bit e, output int lat);
    int     sa, sb, q;
    longint p;
    sa = a;
    sb = b;
    if (is_mul) begin
      p   = longint'(sa) * longint'(sb);
      r   = p[31:0];
      e   = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      lat = MUL_LAT;
    end else if (b == 32'h0) begin
      r = 32'h0; e = 1; lat = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1; lat = DIV_LAT;
    end else begin
      q = sa / sb;
      r = q; e = 0; lat = DIV_LAT;
    end
  endfunction

  // behavioural model: sees the same inputs as the DUT on each rising edge
  initial begin
    int          lat;
    logic [31:0] r;
    bit          e;
    forever begin
      @(posedge clock or negedge resetn);
      if (!resetn) begin
        pending  = 0;
        rdy_exp  = 0;
        held_res = '0;
        held_exc = 0;
      end else begin
        rdy_exp = 0;
        if (bus.ctrl_MULT || bus.ctrl_DIV) begin
          model_op(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB, r, e, lat);
          exp_res = r;
          exp_exc = e;
          pending = 1;
          due     = cyc + lat;
        end else if (pending && cyc == due) begin
          held_res = exp_res;
          held_exc = exp_exc;
          rdy_exp  = 1;
          pending  = 0;
        end
        cyc++;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // single compare process, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (!resetn) begin
        chk("reset_outputs", {31'h0, bus.data_result, bus.data_exception, bus.data_resultRDY}, 64'h0);
      end else begin
        chk("rdy", bus.data_resultRDY, rdy_exp);
        chk("result", bus.data_result, held_res);
        chk("exception", bus.data_exception, held_exc);
        if (lit_id != lit_done_id) begin
          if (bus.data_resultRDY) begin
            chk("lit_rdy_cycle", cyc, lit_due);
            chk("lit_result", bus.data_result, lit_res);
            chk("lit_exception", bus.data_exception, lit_exc);
            lit_done_id = lit_id;
          end else if (cyc > lit_due) begin
            chk("lit_rdy_timeout", cyc, lit_due);
            lit_done_id = lit_id;
          end
        end
      end
    end
  end

  task automatic start_op(input bit mul, input bit dv, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock); #1;
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = dv;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // arm a literal expectation for an op whose start is driven next
  task automatic arm_lit(input logic [31:0] r, input bit e, input int lat);
    lit_res = r;
    lit_exc = e;
    lit_due = cyc + 1 + lat;
    lit_id++;
  endtask

  task automatic wait_lit();
    for (int k = 0; k < 200 && lit_done_id != lit_id; k++) @(negedge clock);
    if (lit_done_id != lit_id) begin
      $display("FAIL lit_wait: checker never resolved expectation %0d", lit_id);
      $fatal(1, "bench stalled");
    end
  endtask

  task automatic run_lit(input bit mul, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input bit e, input int lat);
    @(negedge clock); #1;
    arm_lit(r, e, lat);
    bus.ctrl_MULT     = mul;
    bus.ctrl_DIV      = !mul;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock); #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV  = 1'b0;
    wait_lit();
    repeat (2) @(negedge clock);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] corners [5];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 3))
      0:       return corners[$urandom_range(0, 4)];
      1:       return 32'($signed($urandom_range(0, 200)) - 100);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    resetn            = 1'b0;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    #1 resetn = 1'b1;
    repeat (2) @(negedge clock);

    // directed cases with literal expectations
    run_lit(1, 32'd3, 32'hFFFF_FFF9, 32'hFFFF_FFEB, 0, MUL_LAT);
    run_lit(1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, MUL_LAT);
    run_lit(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, MUL_LAT);
    run_lit(1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 0, MUL_LAT);
    run_lit(0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, DIV_LAT);
    run_lit(0, 32'd100, 32'd7, 32'h0000_000E, 0, DIV_LAT);
    run_lit(0, 32'd5, 32'd0, 32'h0000_0000, 1, 1);
    run_lit(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, DIV_LAT);

    // abort: MULT 2*3, DIV 9/3 sampled at E10
    start_op(1, 0, 32'd2, 32'd3);
    repeat (8) @(negedge clock);
    run_lit(0, 32'd9, 32'd3, 32'd3, 0, DIV_LAT);

    // reset mid-divide, then a clean multiply
    start_op(0, 1, 32'd9, 32'd3);
    repeat (5) @(posedge clock);
    #1 resetn = 1'b0;
    repeat (2) @(negedge clock);
    #1 resetn = 1'b1;
    run_lit(1, 32'd4, 32'd5, 32'h0000_0014, 0, MUL_LAT);

    // randomized ops with random gaps (short gaps abort the running op)
    for (int n = 0; n < 200; n++) begin
      bit both, mul;
      both = ($urandom_range(0, 9) == 0);
      mul  = $urandom_range(0, 1) == 1;
      start_op(mul | both, !mul | both, pick(), pick());
      repeat ($urandom_range(0, 40)) @(negedge clock);
    end
    repeat (40) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
